ray_stepper_search: RTL
=======================

# ray_stepper_search

Parametrised, functional ray stepper for the voxel traversal path. It accepts a ray (start point `q`, signed direction `v`) and an axis-aligned bounding box `[l, u]`. It returns `vp = q + n·v`, where `n` is the smallest positive integer that puts the point outside the box on at least one axis. It generalises the earlier fixed 3-axis stepper stub:
- axis count and search depth are parameters;
- `n` is found by a multiplier-free binary search;
- it reports start-outside and never-exits conditions, and supports abort/restart.

## Interface
- `WIDTH`, default 16: bit width of coordinates `q`, `l`, `u`, `vp` (unsigned) and `v` (two's complement).
- `DIMS`, default 3: number of axes.
- `STEPS`, default 16: binary-search iterations. Must satisfy `STEPS >= WIDTH` so every nonzero `v` exits.
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; forces IDLE and clears all outputs.
- `start` input 1: starts a new operation; `q` and `v` are captured on this cycle.
- `q` input `[WIDTH-1:0] [DIMS-1:0]`: ray origin, unsigned.
- `v` input `[WIDTH-1:0] [DIMS-1:0]`: ray step vector, signed.
- `l` input `[WIDTH-1:0] [DIMS-1:0]`: box lower corner, inclusive. Held constant by the driver while `busy`.
- `u` input `[WIDTH-1:0] [DIMS-1:0]`: box upper corner, inclusive. Held constant by the driver while `busy`.
- `busy` output 1: an operation is in progress.
- `done` output 1: result valid. Held high until the next accepted `start` or `reset`.
- `outOfBounds` output 1: `q` was not inside `[l, u]`; valid with `done`.
- `noExit` output 1: ray never leaves the box within `2^STEPS - 1` steps (e.g. `v = 0`); valid with `done`.
- `vp` output `[WIDTH-1:0] [DIMS-1:0]`: exit point, saturated to `[0, 2^WIDTH-1]` per axis; valid with `done`.

## Operation
- **Inside test:** point `p` is inside iff `l[i] <= p[i] <= u[i]` for all `i`, evaluated on signed internal values. If `l[i] > u[i]` on any axis, every point is outside.
- **Internal width:** signed, `WIDTH+STEPS+2` bits for the accumulator `pos` and candidate computation. No internal overflow is possible.
- **State machine:** IDLE, CHECK, SEARCH, FINISH, DONE.
- **Start:** `start` in any state (including mid-operation) captures `q` and `v`, loads `pos = q`, sets `k = STEPS-1`, clears `done`/`outOfBounds`/`noExit`, sets `busy`, and enters CHECK. An in-flight operation is silently abandoned.
- **CHECK:**
  - If `q` is outside: `outOfBounds = 1`, `vp = q`, enter DONE.
  - Otherwise enter SEARCH.
- **SEARCH** (one iteration per cycle):
  - Compute `cand[i] = pos[i] + (v[i] <<< k)` (arithmetic shift).
  - If `cand` is inside, `pos = cand`.
  - If `k == 0`, enter FINISH; else decrement `k`.
  - Result: `pos` = last inside point `q + n_max·v`. Box convexity makes the inside set a contiguous prefix of `n`, so the search is exact.
- **FINISH:**
  - Compute `e = pos + v`.
  - If `e` is inside: `noExit = 1`, `vp = q`.
  - Else `vp[i] = clamp(e[i], 0, 2^WIDTH-1)`.
  - Enter DONE.
- **DONE:** `done = 1`, `busy = 0`. Outputs are held.
- **IDLE:** reached only from reset.
- A `start` received in the same cycle that the machine would enter DONE takes priority; that completed result is discarded.
- Changing `q` or `v` after the capture cycle has no effect. Changing `l` or `u` while `busy` gives an undefined result; the state machine does not hang.

## Timing
- **Reset values:** `busy = 0`, `done = 0`, `outOfBounds = 0`, `noExit = 0`, `vp = 0`, state IDLE, `pos = 0`, `k = 0`.
- **Start edge:** `start` sampled at edge 0 gives `busy = 1` after edge 0.
- **Normal latency:** `done` rises after edge `STEPS+2` (CHECK 1 + SEARCH `STEPS` + FINISH 1); 18 cycles at default parameters.
- **Out-of-bounds latency:** `done` rises after edge 2.
- **`busy`/`done` exclusivity:** `busy` and `done` are never high together. Both are 0 only in IDLE.
- **Output registration:** all outputs are registered; there is no combinational input-to-output path.
- **Reset mid-operation:** outputs return to reset values immediately (asynchronous). The first `start` after reset deassertion behaves normally.

## Test plan
Default parameters unless stated.
- **Single-axis ray:** `q = (10,10,10)`, `v = (1,0,0)`, `l = (0,0,0)`, `u = (100,100,100)` -> `done` at cycle 18, `vp = (101,10,10)`, flags 0.
- **Diagonal ray:** `q = (50,50,50)`, `v = (-3,2,0)`, `l = (10,10,10)`, `u = (100,100,100)` -> `vp = (8,78,50)` (`n = 14`), flags 0.
- **Origin outside box:** `q = (5,50,50)`, same box -> `done` at cycle 2, `outOfBounds = 1`, `vp = (5,50,50)`.
- **Zero direction:** `v = (0,0,0)`, `q` inside -> `done` at cycle 18, `noExit = 1`, `vp = q`.
- **Saturation:** `q = (65530,0,0)`, `v = (100,0,0)`, `l = 0`, `u = (65535,65535,65535)` -> `vp = (65535,0,0)` (clamped from 65630).
- **Restart and reset:**
  - Case 1 start at cycle 0, new `start` at cycle 5 with case 2 -> `done` only at cycle 23 with case 2 result.
  - `reset` pulsed at cycle 8 of any run -> all outputs 0 at once, state IDLE.

Source files
------------

// File: rtl/ray_stepper_search_if.sv
// Request/result bundle between a ray driver (master) and the ray stepper (slave).
interface ray_stepper_search_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIMS  = 3
);
  logic                       start;
  logic [DIMS-1:0][WIDTH-1:0] q;
  logic [DIMS-1:0][WIDTH-1:0] v;
  logic [DIMS-1:0][WIDTH-1:0] l;
  logic [DIMS-1:0][WIDTH-1:0] u;
  logic                       busy;
  logic                       done;
  logic                       outOfBounds;
  logic                       noExit;
  logic [DIMS-1:0][WIDTH-1:0] vp;

  modport master (output start, q, v, l, u,
                  input  busy, done, outOfBounds, noExit, vp);
  modport slave  (input  start, q, v, l, u,
                  output busy, done, outOfBounds, noExit, vp);
endinterface

// File: rtl/ray_stepper_search.sv
// Ray stepper: finds the first point q + n*v outside box [l, u] using a
// multiplier-free binary search over n, one bit of n per cycle.
module ray_stepper_search #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIMS  = 3,
  parameter int unsigned STEPS = 16
) (
  input  logic               clock,
  input  logic               reset,
  ray_stepper_search_if.slave bus
);
  localparam int unsigned IW = WIDTH + STEPS + 2;
  localparam int unsigned KW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(STEPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SEARCH, S_FINISH, S_DONE} state_t;
  typedef logic [DIMS-1:0][IW-1:0]    ivec_t;
  typedef logic [DIMS-1:0][WIDTH-1:0] wvec_t;

  state_t        state_q, state_d;
  ivec_t         pos_q, pos_d;
  logic [KW-1:0] k_q, k_d;
  wvec_t         q_q, q_d;
  wvec_t         v_q, v_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          oob_q, oob_d;
  logic          noexit_q, noexit_d;
  wvec_t         vp_q, vp_d;

  ivec_t lo, hi, vx, cand, ext;

  function automatic ivec_t widen_u(input wvec_t x);
    ivec_t r;
    for (int i = 0; i < DIMS; i++) r[i] = IW'(x[i]);
    return r;
  endfunction

  function automatic ivec_t widen_s(input wvec_t x);
    ivec_t r;
    for (int i = 0; i < DIMS; i++) r[i] = IW'($signed(x[i]));
    return r;
  endfunction

  // An inverted axis (lo > hi) can never contain a point, so the box is empty.
  function automatic logic is_inside(input ivec_t p, input ivec_t bl, input ivec_t bu);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DIMS; i++) begin
      if ($signed(p[i]) < $signed(bl[i]) || $signed(p[i]) > $signed(bu[i])) r = 1'b0;
    end
    return r;
  endfunction

  function automatic wvec_t clamp(input ivec_t e);
    wvec_t r;
    for (int i = 0; i < DIMS; i++) begin
      if (e[i][IW-1])              r[i] = '0;
      else if (|e[i][IW-2:WIDTH])  r[i] = '1;
      else                         r[i] = e[i][WIDTH-1:0];
    end
    return r;
  endfunction

  // Candidate step of 2^k along v, and the one-step-past point used at FINISH.
  always_comb begin
    lo = widen_u(bus.l);
    hi = widen_u(bus.u);
    vx = widen_s(v_q);
    for (int i = 0; i < DIMS; i++) begin
      cand[i] = pos_q[i] + IW'($signed(vx[i]) <<< k_q);
      ext[i]  = pos_q[i] + vx[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    k_d      = k_q;
    q_d      = q_q;
    v_d      = v_q;
    busy_d   = busy_q;
    done_d   = done_q;
    oob_d    = oob_q;
    noexit_d = noexit_q;
    vp_d     = vp_q;
    if (bus.start) begin
      state_d  = S_CHECK;
      q_d      = bus.q;
      v_d      = bus.v;
      pos_d    = widen_u(bus.q);
      k_d      = K_TOP;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      oob_d    = 1'b0;
      noexit_d = 1'b0;
    end else begin
      unique case (state_q)
        // An outside origin still passes through FINISH so done lands two edges after start.
        S_CHECK: begin
          if (!is_inside(pos_q, lo, hi)) begin
            oob_d   = 1'b1;
            vp_d    = q_q;
            state_d = S_FINISH;
          end else begin
            state_d = S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (is_inside(cand, lo, hi)) pos_d = cand;
          if (k_q == '0) state_d = S_FINISH;
          else           k_d     = k_q - KW'(1);
        end
        S_FINISH: begin
          if (!oob_q) begin
            if (is_inside(ext, lo, hi)) begin
              noexit_d = 1'b1;
              vp_d     = q_q;
            end else begin
              vp_d = clamp(ext);
            end
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pos_q    <= '0;
      k_q      <= '0;
      q_q      <= '0;
      v_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
      noexit_q <= 1'b0;
      vp_q     <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      k_q      <= k_d;
      q_q      <= q_d;
      v_q      <= v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      oob_q    <= oob_d;
      noexit_q <= noexit_d;
      vp_q     <= vp_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.outOfBounds = oob_q;
  assign bus.noExit      = noexit_q;
  assign bus.vp          = vp_q;
endmodule
